// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the CPU memory bus arbiter.
// Optional perf counters are enabled with MIPS_BUS_ARB_PERF_EN.
package mips_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

    localparam logic [31:0] BOOT_BASE = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Two-way round-robin chooser: on a tie the master that
// was not granted most recently wins.
module mips_bus_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick,
    output logic valid
);

    always_comb begin
        pick  = 1'b0;
        valid = req0 | req1;
        unique case (1'b1)
            req0 & req1:  pick = ~last_grant;
            req1 & ~req0: pick = 1'b1;
            default:      pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master to one-slave bus arbiter with registered round-robin grant.
// Define MIPS_BUS_ARB_PERF_EN to add saturating perf counters.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest
`ifdef MIPS_BUS_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_grant0,
    output logic [CNT_W-1:0]  perf_grant1,
    output logic [CNT_W-1:0]  perf_contend
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be positive");
    end

    arb_state_t state;
    logic       last_grant;
    logic       req0, req1;
    logic       gnt0, gnt1;
    logic       pick, pick_valid;
    logic       done;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    mips_bus_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .pick       (pick),
        .valid      (pick_valid)
    );

    // Strobes depend only on state and master inputs, never on s_waitrequest.
    always_comb begin
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        unique case (1'b1)
            gnt0: begin
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                s_read       = m0_read & ~m0_write;
                s_write      = m0_write;
            end
            gnt1: begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                s_read       = m1_read & ~m1_write;
                s_write      = m1_write;
            end
            default: ;
        endcase
    end

    assign done           = (s_read | s_write) & ~s_waitrequest;
    assign m0_waitrequest = ~(gnt0 & done);
    assign m1_waitrequest = ~(gnt1 & done);
    assign m0_readdata    = s_readdata;
    assign m1_readdata    = s_readdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= pick ? GNT1 : GNT0;
                        last_grant <= pick;
                    end
                end
                GNT0: begin
                    if (!req0) begin
                        state <= IDLE;
                    end else if (done) begin
                        if (req1) begin
                            state      <= GNT1;
                            last_grant <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!req1) begin
                        state <= IDLE;
                    end else if (done) begin
                        if (req0) begin
                            state      <= GNT0;
                            last_grant <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIPS_BUS_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant0  <= '0;
            perf_grant1  <= '0;
            perf_contend <= '0;
        end else begin
            if (gnt0 && done && perf_grant0 != '1)
                perf_grant0 <= perf_grant0 + 1'b1;
            if (gnt1 && done && perf_grant1 != '1)
                perf_grant1 <= perf_grant1 + 1'b1;
            if (req0 && req1 && perf_contend != '1)
                perf_contend <= perf_contend + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: master/slave models with a grant
// scoreboard, a vector table and hand-written corner sequences.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } job_t;

    typedef struct {
        bit en0, rd0, wr0;
        bit en1, rd1, wr1;
        int stall;
        bit first;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
`ifdef MIPS_BUS_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_contend;
`endif

    always #5 clk = ~clk;

    mips_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
`ifdef MIPS_BUS_ARB_PERF_EN
        ,
        .perf_grant0    (perf_grant0),
        .perf_grant1    (perf_grant1),
        .perf_contend   (perf_contend)
`endif
    );

    function automatic logic [31:0] rdmodel(logic [31:0] a);
        return (a == BOOT_BASE) ? 32'h3C021234 : (a ^ 32'h5A5A5A5A);
    endfunction

    always_comb s_readdata = rdmodel(s_address);

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stall_cfg = 0;
    int sleft = 0;
    bit sbusy = 0;
    int hold = 0;
    logic [31:0] hold_addr;
    job_t mq0[$], mq1[$], exp0[$], exp1[$];
    int exp_grant[$];
    int comp_cyc[$];
    job_t cur0, cur1;
    bit active0 = 0, active1 = 0, done0 = 0, done1 = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic job_t mk(bit rd, bit wr, logic [31:0] a,
                                logic [31:0] d, logic [3:0] be);
        job_t j;
        j.rd = rd; j.wr = wr; j.addr = a; j.data = d; j.be = be;
        return j;
    endfunction

    task automatic drive_masters();
        m0_read       = active0 & cur0.rd;
        m0_write      = active0 & cur0.wr;
        m0_address    = active0 ? cur0.addr : 32'h0;
        m0_writedata  = active0 ? cur0.data : 32'h0;
        m0_byteenable = active0 ? cur0.be : 4'h0;
        m1_read       = active1 & cur1.rd;
        m1_write      = active1 & cur1.wr;
        m1_address    = active1 ? cur1.addr : 32'h0;
        m1_writedata  = active1 ? cur1.data : 32'h0;
        m1_byteenable = active1 ? cur1.be : 4'h0;
    endtask

    task automatic monitor();
        int   m;
        job_t e;
        logic [31:0] rdat;
        cyc++;
        if (s_read | s_write) begin
            if (hold == 0) hold_addr = s_address;
            hold++;
        end
        if (!m0_waitrequest || !m1_waitrequest) begin
            m = !m1_waitrequest ? 1 : 0;
            check("excl_wait", 32'(m0_waitrequest | m1_waitrequest), 1);
            check("grant_pending", 32'(exp_grant.size() > 0), 1);
            if (exp_grant.size() > 0)
                check("grant_order", m, exp_grant.pop_front());
            check("job_pending", 32'(m ? exp1.size() : exp0.size()), 1);
            if (m ? exp1.size() > 0 : exp0.size() > 0) begin
                e = m ? exp1.pop_front() : exp0.pop_front();
                rdat = m ? m1_readdata : m0_readdata;
                check("s_write", 32'(s_write), 32'(e.wr));
                check("s_read", 32'(s_read), 32'(e.rd & ~e.wr));
                check("s_address", s_address, e.addr);
                check("addr_stable", hold_addr, e.addr);
                check("s_byteenable", 32'(s_byteenable), 32'(e.be));
                check("hold_cycles", hold, stall_cfg + 1);
                if (e.wr) check("s_writedata", s_writedata, e.data);
                else check("readdata", rdat, rdmodel(e.addr));
            end
            comp_cyc.push_back(cyc);
            if (m == 1) done1 = 1; else done0 = 1;
            hold = 0;
            sbusy = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done0) begin active0 = 0; done0 = 0; end
        if (done1) begin active1 = 0; done1 = 0; end
        if (!active0 && mq0.size() > 0) begin
            cur0 = mq0.pop_front(); active0 = 1; exp0.push_back(cur0);
        end
        if (!active1 && mq1.size() > 0) begin
            cur1 = mq1.pop_front(); active1 = 1; exp1.push_back(cur1);
        end
        drive_masters();
        #1;
        if (s_read | s_write) begin
            if (!sbusy) begin sbusy = 1; sleft = stall_cfg; end
            s_waitrequest = (sleft != 0);
            if (sleft != 0) sleft--;
        end else begin
            sbusy = 0;
            s_waitrequest = 1'b0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic run_idle(int max);
        bit idle;
        for (int i = 0; i < max; i++) begin
            idle = !active0 && !active1 && mq0.size() == 0 &&
                   mq1.size() == 0 && exp_grant.size() == 0;
            if (idle) break;
            tick();
        end
        idle = !active0 && !active1 && mq0.size() == 0 &&
               mq1.size() == 0 && exp_grant.size() == 0;
        check("drain", 32'(idle), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq0.delete(); mq1.delete(); exp0.delete(); exp1.delete();
        exp_grant.delete(); comp_cyc.delete();
        active0 = 0; active1 = 0; done0 = 0; done1 = 0;
        sbusy = 0; sleft = 0; hold = 0; stall_cfg = 0;
        s_waitrequest = 1'b0;
        drive_masters();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    vec_t vt[5];
`ifdef MIPS_BUS_ARB_PERF_EN
    logic [31:0] p0, p1;
`endif

    initial begin
        vt[0] = '{1, 1, 0, 1, 1, 0, 0, 1};
        vt[1] = '{1, 1, 1, 0, 0, 0, 1, 0};
        vt[2] = '{1, 0, 1, 1, 0, 1, 2, 1};
        vt[3] = '{0, 0, 0, 1, 1, 0, 0, 1};
        vt[4] = '{1, 0, 1, 1, 1, 0, 1, 0};

        rst = 1'b0;
        s_waitrequest = 1'b0;
        drive_masters();
        #3;
        check("rst_s_read", 32'(s_read), 0);
        check("rst_s_write", 32'(s_write), 0);
        check("rst_w0", 32'(m0_waitrequest), 1);
        check("rst_w1", 32'(m1_waitrequest), 1);
        check("rst_s_addr", s_address, 0);
`ifdef MIPS_BUS_ARB_PERF_EN
        check("rst_perf0", perf_grant0, 0);
        check("rst_perf1", perf_grant1, 0);
        check("rst_perfc", perf_contend, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single master read from boot vector, zero-wait slave
        mq0.push_back(mk(1, 0, BOOT_BASE, 32'h0, 4'hF));
        exp_grant.push_back(0);
        tick();
        check("arb_s_read", 32'(s_read), 0);
        check("arb_w0", 32'(m0_waitrequest), 1);
        tick();
        check("lat_s_read", 32'(s_read), 1);
        check("lat_w0", 32'(m0_waitrequest), 0);
        check("lat_w1", 32'(m1_waitrequest), 1);
        check("boot_rd", m0_readdata, 32'h3C021234);
        run_idle(20);
        tick();
        check("idle_s_read", 32'(s_read), 0);
        check("idle_s_addr", s_address, 0);

        // tie right after reset: m0 first, then m1 with no dead cycle
        do_reset();
        mq0.push_back(mk(1, 0, 32'h0000_1000, 32'h0, 4'hF));
        mq1.push_back(mk(0, 1, 32'h0000_2000, 32'hDEADBEEF, 4'b0011));
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        run_idle(20);
        check("tie_n", comp_cyc.size(), 2);
        if (comp_cyc.size() == 2)
            check("tie_gap", comp_cyc[1] - comp_cyc[0], 1);

        // slave stall of 3 on an m1 write, m0 arrives one cycle later
        stall_cfg = 3;
        mq1.push_back(mk(0, 1, 32'h0000_3000, 32'h12345678, 4'hF));
        exp_grant.push_back(1);
        tick();
        mq0.push_back(mk(1, 0, 32'h0000_4000, 32'h0, 4'hF));
        exp_grant.push_back(0);
        run_idle(40);

        // vector table
        foreach (vt[i]) begin
            stall_cfg = vt[i].stall;
            if (vt[i].en0)
                mq0.push_back(mk(vt[i].rd0, vt[i].wr0, BOOT_BASE + 32'(i * 16),
                                 32'hA000_0000 + 32'(i), 4'(i + 1)));
            if (vt[i].en1)
                mq1.push_back(mk(vt[i].rd1, vt[i].wr1, 32'h8000_0000 + 32'(i * 32),
                                 32'hB000_0000 + 32'(i), 4'(15 - i)));
            if (vt[i].en0 && vt[i].en1) begin
                exp_grant.push_back(int'(vt[i].first));
                exp_grant.push_back(int'(!vt[i].first));
            end else begin
                exp_grant.push_back(vt[i].en1 ? 1 : 0);
            end
            run_idle(40);
        end

        // fairness: ten back-to-back contended transactions
        stall_cfg = 0;
`ifdef MIPS_BUS_ARB_PERF_EN
        p0 = perf_grant0;
        p1 = perf_grant1;
`endif
        for (int k = 0; k < 5; k++) begin
            mq0.push_back(mk(1, 0, 32'h0001_0000 + 32'(k * 4), 32'h0, 4'hF));
            mq1.push_back(mk(0, 1, 32'h0002_0000 + 32'(k * 4),
                             32'hC0DE_0000 + 32'(k), 4'hF));
            exp_grant.push_back(0);
            exp_grant.push_back(1);
        end
        comp_cyc.delete();
        run_idle(60);
        check("fair_n", comp_cyc.size(), 10);
        if (comp_cyc.size() == 10)
            check("fair_span", comp_cyc[9] - comp_cyc[0], 9);
`ifdef MIPS_BUS_ARB_PERF_EN
        check("perf_g0", perf_grant0 - p0, 5);
        check("perf_g1", perf_grant1 - p1, 5);
`endif

        // asynchronous reset in the middle of a stalled m1 transaction
        stall_cfg = 50;
        mq1.push_back(mk(0, 1, 32'h0000_5000, 32'h55AA55AA, 4'hF));
        exp_grant.push_back(1);
        for (int k = 0; k < 10 && !s_write; k++) tick();
        check("mid_start", 32'(s_write), 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_s_write", 32'(s_write), 0);
        check("mid_s_read", 32'(s_read), 0);
        check("mid_w0", 32'(m0_waitrequest), 1);
        check("mid_w1", 32'(m1_waitrequest), 1);
`ifdef MIPS_BUS_ARB_PERF_EN
        check("mid_perf0", perf_grant0, 0);
`endif
        do_reset();
        mq0.push_back(mk(0, 1, 32'h0000_6000, 32'h0F0F0F0F, 4'hC));
        mq1.push_back(mk(1, 0, 32'h0000_7000, 32'h0, 4'hF));
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        run_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU memory bus (read/write/waitrequest/byteenable protocol).
- Shares one RAM/peripheral port between instruction fetch (m0) and load/store (m1), or between the CPU and a future DMA master.
- Registered round-robin grant; each transaction is held until the slave drops waitrequest.
- Sits between the masters and the bus memory model or RAM; passes addresses through untranslated.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
CNT_W, 32, width of the performance counters (only used with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
mN_address  in  ADDR_W  master N address, N=0,1
mN_read  in  1  master N read request
mN_write  in  1  master N write request
mN_writedata  in  DATA_W  master N write data
mN_byteenable  in  BE_W  master N byte lanes
mN_readdata  out  DATA_W  s_readdata, passed through to both masters
mN_waitrequest  out  1  low only in the completing cycle of master N's own transaction
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  BE_W  slave byte lanes
s_readdata  in  DATA_W  slave read data
s_waitrequest  in  1  slave stall

Behaviour:
- Request: reqN = mN_read | mN_write.
- If both mN_read and mN_write are high, write wins and read is suppressed toward the slave.
- FSM states: IDLE, GNT0, GNT1. Registered last_grant bit records the most recent granted master.
- IDLE:
  - only req0 -> GNT0; only req1 -> GNT1.
  - both -> master != last_grant; last_grant <= chosen master.
  - none -> stay in IDLE.
- Arbitration latency: one cycle. A request seen in IDLE at edge k puts the slave strobes on the bus from cycle k+1.
- GNTn, slave side:
  - s_address/s_writedata/s_byteenable = granted master's inputs, combinational mux.
  - s_read = mn_read & ~mn_write; s_write = mn_write.
- GNTn, completion:
  - A transaction completes in a cycle with s_waitrequest=0 and (s_read|s_write)=1.
  - In that cycle mn_waitrequest=0; the master samples s_readdata at the following edge.
- GNTn, next state on completion:
  - other master requesting -> GNT(other), last_grant <= other. This gives back-to-back service with no dead cycle.
  - otherwise -> IDLE.
- GNTn, request withdrawn: if the granted master drops reqn while still in GNTn (protocol violation), go to IDLE next cycle; nothing is issued to the slave.
- Masters not granted: mN_waitrequest=1 whenever not granted or the slave is stalling. This includes IDLE and the arbitration cycle.
- No-request cycles: in IDLE, s_read=s_write=0, s_address/s_writedata/s_byteenable=0.
- Reset (rst=0, asynchronous, any time including mid-transaction):
  - state=IDLE, last_grant=1 so m0 wins the first tie.
  - s_read=s_write=0, both mN_waitrequest=1, counters=0.
  - An aborted transaction is not replayed; the master must re-request after reset.
- No combinational path from s_waitrequest to s_read/s_write. There is a path from s_waitrequest to mN_waitrequest.

Optional Feature:
- Macro: MIPS_BUS_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_grant0 (CNT_W): completed m0 transactions.
  - perf_grant1 (CNT_W): completed m1 transactions.
  - perf_contend (CNT_W): cycles with req0&req1 both high.
- All three counters saturate at all-ones and clear only on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum (IDLE, GNT0, GNT1).
  - localparams for default ADDR_W/DATA_W.
  - BOOT_BASE = 32'hBFC00000 for benches.
- Natural sub-module: mips_bus_rr_pick. Combinational 2-way round-robin chooser: inputs req0, req1, last_grant; outputs pick, valid. Reusable if extended to N masters.

Test Plan:
- Single master: m0 reads 0xBFC00000, slave waitrequest low immediately.
  -> s_read high one cycle after request; m0_waitrequest low in that cycle; m0 captures readdata 0x3C021234; m1_waitrequest stays 1.
- Tie after reset: m0 and m1 request in the same cycle.
  -> m0 granted first (last_grant reset to 1).
  -> on m0 completion, GNT1 directly with no IDLE cycle; m1 write of 0xDEADBEEF, byteenable 4'b0011, reaches the slave unchanged.
- Slave stall: slave holds waitrequest 3 cycles on an m1 write.
  -> s_write/s_address stable for 4 cycles; m1_waitrequest low only in the 4th; m0 request meanwhile sees waitrequest=1 throughout.
- Fairness: both masters request continuously for 10 transactions.
  -> grants alternate 0,1,0,1; each count is 5 (perf_grant0=perf_grant1=5 with MIPS_BUS_ARB_PERF_EN).
- Reset mid-transaction: rst low while in GNT1 with slave stalled.
  -> s_read/s_write=0 and both waitrequests=1 in the same cycle (asynchronous); after release, state IDLE and the next tie goes to m0.
- Read+write both high from m0.
  -> slave sees s_write=1, s_read=0.
